// File: rtl/pc_quantum_unit.sv
// pc_quantum_unit: program counter with user-mode time-slice preemption into the OS
module pc_quantum_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned QW       = 32,
    parameter int unsigned OS_LIMIT = 616,
    parameter int unsigned OS_ENTRY = 0,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] target,
    input  logic             q_load,
    input  logic [QW-1:0]    q_value,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic             preempt,
    output logic             in_user,
    output logic [QW-1:0]    q_count
);
    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(OS_LIMIT);
    localparam logic [WIDTH-1:0] ENTRY_W = WIDTH'(OS_ENTRY);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);
    logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, nxt;
    logic [QW-1:0]    q_count_q, q_count_d, q_limit_q, q_limit_d, cnt_inc;
    logic             preempt_q, preempt_d, expire;
    assign pc      = pc_q;
    assign epc     = epc_q;
    assign preempt = preempt_q;
    assign q_count = q_count_q;
    assign in_user = pc_q >= LIMIT_W;
    // next fetch address, the quantum check and every next-state value; the limit compare uses the pre-load limit
    always_comb begin
        nxt       = pc_sel == 2'b11 ? epc_q
                  : (pc_sel == 2'b01 || (pc_sel == 2'b10 && branch_taken)) ? target
                  : pc_q + WIDTH'(1);
        cnt_inc   = &q_count_q ? q_count_q : q_count_q + QW'(1);
        expire    = in_user && q_limit_q != '0 && q_count_q >= q_limit_q - QW'(1) && !halt;
        pc_d      = halt ? pc_q : expire ? ENTRY_W : nxt;
        epc_d     = expire ? nxt : epc_q;
        q_count_d = halt ? q_count_q : (expire || !in_user) ? '0 : cnt_inc;
        q_limit_d = q_load ? q_value : q_limit_q;
        preempt_d = expire;
    end
    // state registers with synchronous reset taking priority over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_W;
            epc_q     <= '0;
            q_count_q <= '0;
            q_limit_q <= '0;
            preempt_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            q_count_q <= q_count_d;
            q_limit_q <= q_limit_d;
            preempt_q <= preempt_d;
        end
    end
endmodule

// File: tb/tb_pc_quantum_unit.sv
// tb_pc_quantum_unit: directed and randomized checks of the preempting program counter
module tb_pc_quantum_unit;
    logic        clock = 0;
    logic        reset, halt, branch_taken, q_load;
    logic [1:0]  pc_sel;
    logic [31:0] target, q_value, pc, epc, q_count;
    logic        preempt, in_user;
    logic        s_reset, s_halt, s_branch_taken, s_q_load;
    logic [1:0]  s_pc_sel;
    logic [7:0]  s_target, s_q_value, s_pc, s_epc, s_q_count;
    logic        s_preempt, s_in_user;
    logic [31:0] m_pc, m_epc, m_cnt, m_lim;
    bit          m_pre;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    pc_quantum_unit dut (
        .clock(clock), .reset(reset), .halt(halt), .pc_sel(pc_sel),
        .branch_taken(branch_taken), .target(target), .q_load(q_load),
        .q_value(q_value), .pc(pc), .epc(epc), .preempt(preempt),
        .in_user(in_user), .q_count(q_count)
    );

    pc_quantum_unit #(.WIDTH(8), .QW(8), .OS_LIMIT(16)) sdut (
        .clock(clock), .reset(s_reset), .halt(s_halt), .pc_sel(s_pc_sel),
        .branch_taken(s_branch_taken), .target(s_target), .q_load(s_q_load),
        .q_value(s_q_value), .pc(s_pc), .epc(s_epc), .preempt(s_preempt),
        .in_user(s_in_user), .q_count(s_q_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each non-halted user cycle executes one more instruction of the current quantum;
    // the instruction that brings the executed total up to the limit is the last before the redirect.
    task automatic step(input string tag);
        logic [31:0] dest;
        bit user, last;
        user = m_pc >= 32'd616;
        case (pc_sel)
            2'd0: dest = m_pc + 32'd1;
            2'd1: dest = target;
            2'd2: dest = branch_taken ? target : m_pc + 32'd1;
            default: dest = m_epc;
        endcase
        last = !halt && user && m_lim != 0 && (longint'(m_cnt) + 1 >= longint'(m_lim));
        if (reset) begin
            m_pc = 0; m_epc = 0; m_cnt = 0; m_lim = 0; m_pre = 0;
        end else begin
            if (q_load) m_lim = q_value;
            if (halt) m_pre = 0;
            else if (last) begin
                m_epc = dest; m_pc = 0; m_cnt = 0; m_pre = 1;
            end else begin
                m_pc = dest;
                m_cnt = !user ? 0 : (m_cnt == 32'hFFFF_FFFF ? m_cnt : m_cnt + 1);
                m_pre = 0;
            end
        end
        @(posedge clock);
        #1;
        chk({tag, " pc"}, pc, m_pc);
        chk({tag, " epc"}, epc, m_epc);
        chk({tag, " q_count"}, q_count, m_cnt);
        chk({tag, " preempt"}, preempt, m_pre);
        chk({tag, " in_user"}, in_user, m_pc >= 32'd616);
    endtask

    task automatic stick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1; halt = 0; pc_sel = 0; branch_taken = 0; target = 0; q_load = 0; q_value = 0;
        s_reset = 1; s_halt = 0; s_pc_sel = 0; s_branch_taken = 0; s_target = 0; s_q_load = 0; s_q_value = 0;
        m_pc = 'x; m_epc = 'x; m_cnt = 'x; m_lim = 'x; m_pre = 0;
        step("reset");
        chk("reset pc", pc, 0);
        reset = 0;
        for (int i = 1; i <= 5; i++) begin
            step("seq");
            chk("seq pc", pc, i);
        end
        q_load = 1; q_value = 4; step("load4"); q_load = 0;
        pc_sel = 1; target = 620; step("jump620"); pc_sel = 0;
        chk("enter pc", pc, 620);
        for (int i = 0; i < 3; i++) step("user4");
        chk("last user pc", pc, 623);
        step("expire4");
        chk("expire pc", pc, 0);
        chk("expire epc", epc, 624);
        chk("expire preempt", preempt, 1);
        pc_sel = 3; step("ret"); pc_sel = 0;
        chk("ret pc", pc, 624);
        chk("ret preempt", preempt, 0);
        for (int i = 0; i < 4; i++) step("user4b");
        chk("expire2 epc", epc, 628);
        chk("expire2 preempt", preempt, 1);
        q_load = 1; q_value = 3; step("load3"); q_load = 0;
        pc_sel = 1; target = 620; step("jump620b"); pc_sel = 0;
        halt = 1;
        for (int i = 0; i < 10; i++) step("halt");
        chk("halt pc", pc, 620);
        chk("halt q_count", q_count, 0);
        halt = 0;
        for (int i = 0; i < 3; i++) step("after halt");
        chk("halt expire epc", epc, 623);
        chk("halt expire preempt", preempt, 1);
        q_load = 1; q_value = 2; step("load2"); q_load = 0;
        pc_sel = 1; target = 620; step("jump620c"); pc_sel = 0;
        step("user2");
        pc_sel = 1; target = 700; q_load = 1; q_value = 0; step("expire jump");
        pc_sel = 0; q_load = 0;
        chk("jump expire pc", pc, 0);
        chk("jump expire epc", epc, 700);
        chk("jump expire preempt", preempt, 1);
        pc_sel = 1; target = 620; step("jump620d"); pc_sel = 0;
        for (int i = 0; i < 10; i++) step("no quantum");
        chk("no quantum q_count", q_count, 10);
        chk("no quantum preempt", preempt, 0);
        for (int i = 0; i < 400; i++) begin
            automatic int r = $urandom_range(0, 9);
            reset = $urandom_range(0, 63) == 0;
            halt = $urandom_range(0, 7) == 0;
            pc_sel = r < 6 ? 2'd0 : r < 8 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
            branch_taken = $urandom_range(0, 1) == 1;
            target = $urandom_range(0, 1000);
            q_load = $urandom_range(0, 5) == 0;
            q_value = $urandom_range(0, 6);
            step("random");
        end
        reset = 0; halt = 0; q_load = 0; pc_sel = 0;
        stick();
        s_reset = 0; s_pc_sel = 1; s_target = 255; stick();
        chk("small pc 255", s_pc, 255);
        chk("small user at 255", s_in_user, 1);
        s_pc_sel = 0; stick();
        chk("small wrap pc", s_pc, 0);
        chk("small wrap in_user", s_in_user, 0);
        chk("small wrap q_count", s_q_count, 1);
        s_pc_sel = 1; s_target = 20; stick();
        s_pc_sel = 0; stick(); stick();
        chk("small count", s_q_count, 2);
        chk("small no preempt", s_preempt, 0);
        s_reset = 1; stick();
        chk("small reset pc", s_pc, 0);
        chk("small reset epc", s_epc, 0);
        chk("small reset q_count", s_q_count, 0);
        chk("small reset preempt", s_preempt, 0);
        chk("small reset in_user", s_in_user, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
